// File: rtl/ysyx_22050243_branch_ctrl_pkg.sv
// Shared definitions for the branch controller: FSM states, 2-bit predictor
// counter encodings and the saturating counter update rule.
package ysyx_22050243_branch_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REDIRECT = 2'd1,
    S_FLUSH    = 2'd2
  } ctrl_state_e;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  localparam logic [1:0] BHT_RESET_VAL = CTR_WNT;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ysyx_22050243_branch_ctrl_if.sv
// EX-result and IF-redirect handshakes between the pipeline and the branch
// controller; master is the pipeline side, slave is the controller.
interface ysyx_22050243_branch_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             ex_valid;
  logic             ex_ready;
  logic [WIDTH-1:0] ex_pc;
  logic             ex_taken;
  logic [WIDTH-1:0] ex_target;
  logic             ex_pred_taken;
  logic             redir_valid;
  logic             redir_ready;
  logic [WIDTH-1:0] redir_pc;

  modport master (
    output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, redir_ready,
    input  ex_ready, redir_valid, redir_pc
  );

  modport slave (
    input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, redir_ready,
    output ex_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/ysyx_22050243_bht.sv
// Table of 2-bit saturating counters. The lookup is combinational off the
// registered table, so a same-cycle update at the same index is not visible.
module ysyx_22050243_bht
  import ysyx_22050243_branch_ctrl_pkg::*;
#(
  parameter int IDX = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [IDX-1:0] lookup_idx,
  output logic [1:0]     lookup_ctr,
  input  logic           upd_en,
  input  logic [IDX-1:0] upd_idx,
  input  logic           upd_taken
);

  localparam int ENTRIES = 2 ** IDX;

  logic [1:0] table_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= BHT_RESET_VAL;
    end else if (upd_en) begin
      table_q[upd_idx] <= ctr_next(table_q[upd_idx], upd_taken);
    end
  end

  assign lookup_ctr = table_q[lookup_idx];

endmodule

// File: rtl/ysyx_22050243_branch_ctrl.sv
// Branch resolution controller: accepts resolved branches from EX, trains the
// BHT, and on a misprediction issues a redirect to IF followed by a flush pulse.
module ysyx_22050243_branch_ctrl
  import ysyx_22050243_branch_ctrl_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int BHT_IDX      = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             if_pc,
  output logic                         if_pred_taken,
  ysyx_22050243_branch_ctrl_if.slave   ctrl_bus,
  output logic                         flush,
  output logic [31:0]                  perf_branches,
  output logic [31:0]                  perf_mispred
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] FLUSH_RELOAD = CNT_W'(FLUSH_CYCLES - 1);

  ctrl_state_e       state_q, state_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [WIDTH-1:0]  redir_pc_q, redir_pc_d;
  logic [31:0]       perf_branches_q, perf_mispred_q;
  logic              in_idle, handshake, mispredict, redir_valid;
  logic [1:0]        lookup_ctr;
  logic              unused_pc_bits;

  assign in_idle    = (state_q == S_IDLE);
  assign handshake  = ctrl_bus.ex_valid & in_idle;
  assign mispredict = handshake & (ctrl_bus.ex_taken != ctrl_bus.ex_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_cnt_q <= '0;
      redir_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      redir_pc_q  <= redir_pc_d;
    end
  end

  // The flush pulse starts in the redirect acceptance cycle; FLUSH covers the rest.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    redir_pc_d  = redir_pc_q;
    redir_valid = 1'b0;
    flush       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mispredict) begin
          redir_pc_d = ctrl_bus.ex_taken ? ctrl_bus.ex_target
                                         : ctrl_bus.ex_pc + WIDTH'(4);
          state_d    = S_REDIRECT;
        end
      end
      S_REDIRECT: begin
        redir_valid = 1'b1;
        if (ctrl_bus.redir_ready) begin
          flush = 1'b1;
          if (FLUSH_CYCLES == 1) begin
            state_d = S_IDLE;
          end else begin
            state_d     = S_FLUSH;
            flush_cnt_d = FLUSH_RELOAD;
          end
        end
      end
      S_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q <= CNT_W'(1)) begin
          state_d     = S_IDLE;
          flush_cnt_d = '0;
        end else begin
          flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches_q <= '0;
      perf_mispred_q  <= '0;
    end else begin
      if (handshake)  perf_branches_q <= perf_branches_q + 32'd1;
      if (mispredict) perf_mispred_q  <= perf_mispred_q + 32'd1;
    end
  end

  ysyx_22050243_bht #(.IDX(BHT_IDX)) u_bht (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (if_pc[BHT_IDX+1:2]),
    .lookup_ctr (lookup_ctr),
    .upd_en     (handshake),
    .upd_idx    (ctrl_bus.ex_pc[BHT_IDX+1:2]),
    .upd_taken  (ctrl_bus.ex_taken)
  );

  assign unused_pc_bits = ^{if_pc[WIDTH-1:BHT_IDX+2], if_pc[1:0], lookup_ctr[0]};

  assign if_pred_taken        = lookup_ctr[1];
  assign ctrl_bus.ex_ready    = in_idle;
  assign ctrl_bus.redir_valid = redir_valid;
  assign ctrl_bus.redir_pc    = redir_pc_q;
  assign perf_branches        = perf_branches_q;
  assign perf_mispred         = perf_mispred_q;

endmodule

// File: tb/tb_ysyx_22050243_branch_ctrl.sv
// Randomized plus directed bench for the branch controller, checked against a
// cycle-level behavioural model of the redirect/flush protocol and predictor.
module tb_ysyx_22050243_branch_ctrl;

  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = 32'h0;
  logic        if_pred_taken;
  logic        flush;
  logic [31:0] perf_branches, perf_mispred;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int unsigned bht_m [16];
  bit          pending;
  logic [31:0] redir_addr;
  int          flush_left;
  logic [31:0] m_branches, m_mispred;

  always #5 clk = ~clk;

  ysyx_22050243_branch_ctrl_if #(.WIDTH(32)) bus ();

  ysyx_22050243_branch_ctrl #(
    .WIDTH(32), .BHT_IDX(4), .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_pred_taken (if_pred_taken),
    .ctrl_bus      (bus),
    .flush         (flush),
    .perf_branches (perf_branches),
    .perf_mispred  (perf_mispred)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    pending    = 1'b0;
    redir_addr = 32'h0;
    flush_left = 0;
    m_branches = 32'h0;
    m_mispred  = 32'h0;
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] pc, input bit tk,
                               input logic [31:0] tgt, input bit pr, input bit rr,
                               input logic [31:0] ipc);
    bit ready_e, flush_e, pred_e, hs;
    @(negedge clk);
    rst               = r;
    bus.ex_valid      = v;
    bus.ex_pc         = pc;
    bus.ex_taken      = tk;
    bus.ex_target     = tgt;
    bus.ex_pred_taken = pr;
    bus.redir_ready   = rr;
    if_pc             = ipc;
    #1;
    ready_e = !pending && (flush_left == 0);
    flush_e = (pending && rr) || (flush_left > 0);
    pred_e  = (bht_m[(ipc >> 2) % 16] >= 2);
    checkOutput("if_pred_taken", {31'h0, if_pred_taken}, {31'h0, pred_e});
    checkOutput("ex_ready", {31'h0, bus.ex_ready}, {31'h0, ready_e});
    checkOutput("redir_valid", {31'h0, bus.redir_valid}, {31'h0, pending});
    checkOutput("redir_pc", bus.redir_pc, redir_addr);
    checkOutput("flush", {31'h0, flush}, {31'h0, flush_e});
    checkOutput("perf_branches", perf_branches, m_branches);
    checkOutput("perf_mispred", perf_mispred, m_mispred);
    hs = v && ready_e;
    if (r) begin
      modelReset();
    end else if (hs) begin
      int unsigned k;
      k = (pc >> 2) % 16;
      m_branches = m_branches + 1;
      if (tk != pr) begin
        m_mispred  = m_mispred + 1;
        pending    = 1'b1;
        redir_addr = tk ? tgt : pc + 32'd4;
      end
      if (tk) bht_m[k] = (bht_m[k] == 3) ? 3 : bht_m[k] + 1;
      else    bht_m[k] = (bht_m[k] == 0) ? 0 : bht_m[k] - 1;
    end else if (pending && rr) begin
      pending    = 1'b0;
      flush_left = FLUSH_CYCLES - 1;
    end else if (flush_left > 0) begin
      flush_left--;
    end
    @(posedge clk);
  endtask

  task automatic idleCycle(input bit rr, input logic [31:0] ipc);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, rr, ipc);
  endtask

  function automatic logic [31:0] randPc();
    logic [5:0] off;
    off = 6'($urandom);
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    return {24'h800000, off, 2'b00};
  endfunction

  initial begin
    bus.ex_valid = 1'b0; bus.ex_pc = '0; bus.ex_taken = 1'b0;
    bus.ex_target = '0; bus.ex_pred_taken = 1'b0; bus.redir_ready = 1'b0;
    repeat (2) @(posedge clk);
    modelReset();

    // After reset: prediction, counters and ready
    idleCycle(1'b0, 32'h8000_0000);

    // Taken but predicted not-taken, IF accepts immediately
    applyStimulus(1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0100, 1'b0, 1'b1, 32'h8000_0010);
    repeat (4) idleCycle(1'b1, 32'h8000_0010);

    // Not-taken but predicted taken, IF stalls the redirect for 3 cycles
    applyStimulus(1'b0, 1'b1, 32'h8000_0020, 1'b0, 32'h8000_0500, 1'b1, 1'b0, 32'h8000_0020);
    repeat (3) applyStimulus(1'b0, 1'b1, 32'h8000_0030, 1'b1, 32'h8000_0700, 1'b0, 1'b0, 32'h8000_0020);
    repeat (4) idleCycle(1'b1, 32'h8000_0020);

    // Saturate entry 1, then look it up through an aliasing PC
    repeat (3) applyStimulus(1'b0, 1'b1, 32'h8000_0004, 1'b1, 32'h8000_0200, 1'b1, 1'b0, 32'h8000_0044);
    idleCycle(1'b0, 32'h8000_0044);

    // Reset in the middle of a flush
    applyStimulus(1'b0, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0300, 1'b0, 1'b0, 32'h8000_0008);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8000_0008);
    applyStimulus(1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0300, 1'b1, 1'b1, 32'h8000_0008);
    for (int i = 0; i < 16; i++) idleCycle(1'b0, 32'h8000_0000 + 32'(4 * i));

    // Branch counter wrap via backdoor preload
    #2 force dut.perf_branches_q = 32'hFFFF_FFFF;
    #1 release dut.perf_branches_q;
    m_branches = 32'hFFFF_FFFF;
    applyStimulus(1'b0, 1'b1, 32'h8000_0040, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8000_0040);
    idleCycle(1'b0, 32'h8000_0040);

    // Randomized traffic, with the occasional synchronous reset
    for (int n = 0; n < 800; n++) begin
      bit r, v, tk, pr, rr;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 3) != 0);
      tk = 1'($urandom);
      pr = ($urandom_range(0, 3) == 0) ? ~tk : tk;
      rr = 1'($urandom);
      applyStimulus(r, v, randPc(), tk, $urandom, pr, rr, randPc());
    end
    idleCycle(1'b1, 32'h8000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
